fp_rc_slew_tracker: RTL
=======================

// Module: fp_rc_slew_tracker
// PURPOSE
//  Sequential consumer of a 34-bit signed fixed-point "analog" value, such as
//  the output of the muxed fixed-point constant stages.
//  Models a first-order RC response: out follows in_analog by 2^-SHIFT of the
//  error on each enabled cycle. Flags input steps and reports when the output
//  has settled within TOL for SETTLE_CYCLES enabled cycles.
// PARAMETERS
//  WIDTH          34   signed fixed-point width of in/out (two's complement)
//  FRAC           13   fractional bits; informational, 1.0 = 2^FRAC = 8192
//  SHIFT          4    filter coefficient alpha = 2^-SHIFT, range 1..8
//  TOL            64   settle tolerance on |in - out|, in LSBs, unsigned
//  SETTLE_CYCLES  8    consecutive in-tolerance enabled cycles before settled=1
// PORTS
//  clk         in   1      clock; all state updates on posedge
//  reset       in   1      synchronous reset, active-low
//  en          in   1      sample/update enable; 0 = hold all state
//  init        in   1      with en=1: preload out_analog <= in_analog
//  in_analog   in   WIDTH  signed fixed-point target value
//  out_analog  out  WIDTH  registered, filtered fixed-point value
//  out_valid   out  1      1 once the first sample after reset has loaded
//  settled     out  1      1 while in tolerance for >= SETTLE_CYCLES cycles
//  step        out  1      1-cycle pulse: sampled input differs from previous
// BEHAVIOUR
//  Reset: reset==0 at posedge -> out_analog=0, out_valid=0, settled=0, step=0.
//    Also clears prev_in=0, cnt=0, state=IDLE. Reset overrides en and init,
//    including mid-operation.
//  All outputs are registered. Results of an en cycle appear on the next posedge.
//  en=0: no state change. step=0. All other outputs hold.
//  FSM states: IDLE, TRACK, SETTLED.
//   IDLE + en=1 -> preload. TRACK/SETTLED + en=1 + init=1 -> preload.
//   Preload: out<=in, prev_in<=in, out_valid<=1, cnt<=0, settled<=0,
//     step<=0, state<=TRACK.
//   TRACK/SETTLED + en=1 + init=0 -> filter update:
//    diff  = in - out, computed WIDTH+1 bits signed (no overflow).
//    delta = diff >>> SHIFT (arithmetic shift).
//    If delta==0 and diff!=0, delta = +1 or -1 per sign(diff).
//      This guarantees exact convergence.
//    out <= out + delta. The result always lies between out and in, so no
//      saturation is needed. The sum is truncated to WIDTH.
//    step <= (in != prev_in). prev_in <= in.
//    |diff| <= TOL: cnt <= min(cnt+1, SETTLE_CYCLES).
//      settled <= 1 when cnt+1 >= SETTLE_CYCLES; state <= SETTLED.
//    |diff| > TOL: cnt<=0, settled<=0, state<=TRACK, in the same edge.
//    diff and the tolerance test use the pre-update out value.
//  settled drops on the same edge that step rises when a step exceeds TOL.
//  |diff| for diff = -2^WIDTH is handled in WIDTH+1 bits without wrap.
// TESTING
//  1 reset=0 for 2 cycles, en=1, in=55361536 -> out=0, out_valid=0,
//    settled=0, step=0.
//  2 Release reset, en=1, in=55361536 -> next edge out=55361536, out_valid=1.
//    settled=1 on the 8th following en cycle.
//  3 Settled at 55361536, in->0 -> step=1 for one cycle, out=51901440,
//    settled=0. Next edge out=48657600.
//  4 out=0, in=5, SHIFT=4 -> out steps +1 per cycle to 5 and stays there.
//    No stall at 0.
//  5 Mid-track, en=0 for 10 cycles with in changing -> all outputs frozen,
//    step=0.
//  6 reset=0 while TRACK with en=1,init=1 -> all outputs 0, IDLE.
//    Next en preloads in.

Source files
------------

// File: rtl/fp_rc_slew_tracker.sv
// fp_rc_slew_tracker
//   First-order RC slew tracker for a signed fixed-point value. On each enabled
//   cycle the output moves toward the input by 2^-SHIFT of the error. It always
//   moves by at least one LSB, so the output converges exactly. A one-cycle
//   step pulse flags a change in the sampled input. The settled flag rises
//   after SETTLE_CYCLES consecutive enabled cycles with |in - out| <= TOL.
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_reset      synchronous reset, active-low
//   i_en         sample/update enable (0 holds all state)
//   i_init       with i_en: preload output with the input
//   i_in_analog  signed fixed-point target (two's complement, WIDTH bits)
//   o_out_analog registered filtered value
//   o_out_valid  set once the first sample after reset has loaded
//   o_settled    in tolerance for at least SETTLE_CYCLES enabled cycles
//   o_step       one-cycle pulse, sampled input differs from the previous one
module fp_rc_slew_tracker #(
  parameter int WIDTH         = 34,
  parameter int FRAC          = 13,
  parameter int SHIFT         = 4,
  parameter int TOL           = 64,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_init,
  input  logic [WIDTH-1:0] i_in_analog,
  output logic [WIDTH-1:0] o_out_analog,
  output logic             o_out_valid,
  output logic             o_settled,
  output logic             o_step
);

  localparam int              CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [WIDTH:0]   TOL_U   = (WIDTH + 1)'(TOL);

  // FRAC only documents the binary point; it is checked here for sanity.
  if (SHIFT < 1 || SHIFT > 8 || FRAC < 0 || FRAC >= WIDTH) begin : g_param_check
    $error("fp_rc_slew_tracker: SHIFT must be 1..8 and FRAC within WIDTH");
  end

  typedef enum logic [1:0] {IDLE, TRACK, SETTLED} state_t;

  state_t                  r_state,   w_state_nxt;
  logic signed [WIDTH-1:0] r_out,     w_out_nxt;
  logic signed [WIDTH-1:0] r_prev_in, w_prev_nxt;
  logic                    r_valid,   w_valid_nxt;
  logic                    r_settled, w_settled_nxt;
  logic                    r_step,    w_step_nxt;
  logic [CNT_W-1:0]        r_cnt,     w_cnt_nxt;

  logic signed [WIDTH-1:0] w_in;
  logic signed [WIDTH:0]   w_diff;
  logic signed [WIDTH:0]   w_delta;
  logic signed [WIDTH:0]   w_sum;
  logic [WIDTH:0]          w_abs_diff;

  // Arithmetic shift, forced to at least one LSB toward the target so the
  // filter cannot stall short of the input.
  function automatic logic signed [WIDTH:0] slew_delta(input logic signed [WIDTH:0] diff);
    logic signed [WIDTH:0] d;
    d = diff >>> SHIFT;
    if (d == '0 && diff != '0) begin
      d = diff[WIDTH] ? {(WIDTH + 1){1'b1}} : {{WIDTH{1'b0}}, 1'b1};
    end
    return d;
  endfunction

  // Magnitude as an unsigned WIDTH+1 value, so -2^WIDTH maps to 2^WIDTH.
  function automatic logic [WIDTH:0] mag(input logic signed [WIDTH:0] v);
    logic signed [WIDTH:0] n;
    n = -v;
    return v[WIDTH] ? $unsigned(n) : $unsigned(v);
  endfunction

  assign w_in       = $signed(i_in_analog);
  assign w_diff     = $signed({w_in[WIDTH-1], w_in}) - $signed({r_out[WIDTH-1], r_out});
  assign w_delta    = slew_delta(w_diff);
  assign w_abs_diff = mag(w_diff);
  // The sum lies between out and in, so truncating to WIDTH is exact.
  assign w_sum      = $signed({r_out[WIDTH-1], r_out}) + w_delta;

  always_comb begin
    w_state_nxt   = r_state;
    w_out_nxt     = r_out;
    w_prev_nxt    = r_prev_in;
    w_valid_nxt   = r_valid;
    w_settled_nxt = r_settled;
    w_step_nxt    = 1'b0;
    w_cnt_nxt     = r_cnt;
    if (i_en) begin
      if (r_state == IDLE || i_init) begin
        w_out_nxt     = w_in;
        w_prev_nxt    = w_in;
        w_valid_nxt   = 1'b1;
        w_cnt_nxt     = '0;
        w_settled_nxt = 1'b0;
        w_state_nxt   = TRACK;
      end else begin
        w_out_nxt  = w_sum[WIDTH-1:0];
        w_step_nxt = (w_in != r_prev_in);
        w_prev_nxt = w_in;
        if (w_abs_diff <= TOL_U) begin
          w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
          if (int'(r_cnt) + 1 >= SETTLE_CYCLES) begin
            w_settled_nxt = 1'b1;
            w_state_nxt   = SETTLED;
          end else begin
            w_settled_nxt = 1'b0;
            w_state_nxt   = TRACK;
          end
        end else begin
          w_cnt_nxt     = '0;
          w_settled_nxt = 1'b0;
          w_state_nxt   = TRACK;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_out     <= '0;
      r_prev_in <= '0;
      r_valid   <= 1'b0;
      r_settled <= 1'b0;
      r_step    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_out     <= w_out_nxt;
      r_prev_in <= w_prev_nxt;
      r_valid   <= w_valid_nxt;
      r_settled <= w_settled_nxt;
      r_step    <= w_step_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign o_out_analog = r_out;
  assign o_out_valid  = r_valid;
  assign o_settled    = r_settled;
  assign o_step       = r_step;

endmodule
